batch_accum_taint: RTL and testbench

Downstream consumer of the buffered-multiplier output stream. It sums incoming products in batches of BATCH and emits one registered result pulse per batch. A batch closes early when the sum saturates, so result timing depends on the data. Every data/control signal carries a 1-bit coarse taint companion; the block propagates taint under the basic (conservative OR) policy used across the taint library, so information-flow checks can run on the full mul → buffer → accumulate chain.

---
 rtl/batch_accum_taint.sv | 85 ++++++++
 tb/tb_batch_accum_taint.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/batch_accum_taint.sv
// Batch accumulator for the multiplier product stream: sums BATCH products (or
// fewer, if the sum saturates) and emits one registered result pulse per batch, with coarse taint.
module batch_accum_taint #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 9,
    parameter int BATCH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_valid_t,
    input  logic [2*WIDTH-1:0]     in_data,
    input  logic                   in_data_t,
    output logic                   out_valid,
    output logic                   out_valid_t,
    output logic [ACC_WIDTH-1:0]   out_sum,
    output logic                   out_sum_t,
    output logic [2:0]             out_count,
    output logic                   out_sat
);

    localparam int PW = 2 * WIDTH;

    logic [ACC_WIDTH-1:0] acc;
    logic [2:0]           cnt;
    logic                 acc_t;
    logic                 cnt_t;
    logic                 ctl_t;

    logic [ACC_WIDTH:0]   nsum;
    logic [2:0]           cnt_inc;
    logic                 sat;
    logic                 close;

    always_comb begin
        nsum    = {1'b0, acc} + {{(ACC_WIDTH + 1 - PW){1'b0}}, in_data};
        sat     = nsum[ACC_WIDTH];
        cnt_inc = cnt + 3'd1;
        close   = sat || (cnt_inc == 3'(BATCH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                if (close) begin
                    out_valid <= 1'b1;
                    out_sum   <= sat ? '1 : nsum[ACC_WIDTH-1:0];
                    out_count <= cnt_inc;
                    out_sat   <= sat;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= nsum[ACC_WIDTH-1:0];
                    cnt <= cnt_inc;
                end
            end
        end
    end

    // Sticky taint: saturation lets data steer cnt, so data taint reaches cnt_t too.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_t     <= 1'b0;
            cnt_t     <= 1'b0;
            ctl_t     <= 1'b0;
            out_sum_t <= 1'b0;
        end else begin
            cnt_t     <= cnt_t | in_valid_t | acc_t | in_data_t;
            acc_t     <= acc_t | in_valid_t | in_data_t;
            ctl_t     <= in_valid_t | in_data_t;
            out_sum_t <= out_sum_t | acc_t | in_data_t | in_valid_t;
        end
    end

    assign out_valid_t = cnt_t | acc_t | ctl_t;

endmodule

// File: tb/tb_batch_accum_taint.sv
// Scoreboard bench for batch_accum_taint: directed beats push expected pulses,
// a negedge monitor pops and compares; a second copy checks taint conservativeness.
module tb_batch_accum_taint;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_valid_t, in_data_t;
    logic [7:0] in_data;
    logic [7:0] data_b;
    logic [7:0] in_data_b;
    logic       two_copy;

    logic       out_valid, out_valid_t, out_sum_t, out_sat;
    logic [8:0] out_sum;
    logic [2:0] out_count;
    logic       out_valid_b, out_valid_t_b, out_sum_t_b, out_sat_b;
    logic [8:0] out_sum_b;
    logic [2:0] out_count_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [8:0] sum;
        logic [2:0] count;
        logic       sat;
        logic       sum_t;
        logic       valid_t;
        int         at;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign in_data_b = two_copy ? data_b : in_data;

    batch_accum_taint #(.WIDTH(4), .ACC_WIDTH(9), .BATCH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_valid_t(in_valid_t),
        .in_data(in_data), .in_data_t(in_data_t),
        .out_valid(out_valid), .out_valid_t(out_valid_t),
        .out_sum(out_sum), .out_sum_t(out_sum_t),
        .out_count(out_count), .out_sat(out_sat)
    );

    batch_accum_taint #(.WIDTH(4), .ACC_WIDTH(9), .BATCH(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_valid_t(in_valid_t),
        .in_data(in_data_b), .in_data_t(in_data_t),
        .out_valid(out_valid_b), .out_valid_t(out_valid_t_b),
        .out_sum(out_sum_b), .out_sum_t(out_sum_t_b),
        .out_count(out_count_b), .out_sat(out_sat_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called just after an edge, before the closing beat is presented.
    task automatic expect_pulse(input logic [8:0] s, input logic [2:0] c, input logic st,
                                input logic sumt, input logic vt);
        exp_t e;
        e.sum = s; e.count = c; e.sat = st; e.sum_t = sumt; e.valid_t = vt;
        e.at = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic vt, input logic dt,
                        input logic [7:0] db);
        in_valid = v; in_data = d; in_valid_t = vt; in_data_t = dt; data_b = db;
        @(posedge clk); #1;
    endtask

    task automatic beat(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, d);
    endtask

    task automatic idle();
        step(1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(out_sum), 32'h0);
                check("unexpected_pulse_present", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.at));
                check("out_sum", 32'(out_sum), 32'(e.sum));
                check("out_count", 32'(out_count), 32'(e.count));
                check("out_sat", 32'(out_sat), 32'(e.sat));
                check("out_sum_t", 32'(out_sum_t), 32'(e.sum_t));
                check("out_valid_t", 32'(out_valid_t), 32'(e.valid_t));
            end
        end
    end

    initial begin
        int ndiff;
        rst = 1'b1; two_copy = 1'b0;
        in_valid = 1'b0; in_data = '0; in_valid_t = 1'b0; in_data_t = 1'b0; data_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_out_valid_t", 32'(out_valid_t), 32'd0);
        check("rst_out_sum_t", 32'(out_sum_t), 32'd0);
        rst = 1'b0;

        // Plain batch of four
        beat(8'd10); beat(8'd20); beat(8'd30);
        expect_pulse(9'd100, 3'd4, 1'b0, 1'b0, 1'b0);
        beat(8'd40);
        idle(); idle();
        check("hold_out_sum", 32'(out_sum), 32'd100);
        check("hold_out_count", 32'(out_count), 32'd4);
        check("hold_out_valid_low", 32'(out_valid), 32'd0);
        check("notaint_valid_t", 32'(out_valid_t), 32'd0);
        check("notaint_sum_t", 32'(out_sum_t), 32'd0);

        // Saturation closes early; next batch starts from zero
        beat(8'd200); beat(8'd200);
        expect_pulse(9'd511, 3'd3, 1'b1, 1'b0, 1'b0);
        beat(8'd200);
        beat(8'd5); beat(8'd1); beat(8'd1);
        expect_pulse(9'd8, 3'd4, 1'b0, 1'b0, 1'b0);
        beat(8'd1);
        idle();

        // Back-to-back batches
        for (int i = 1; i <= 8; i++) begin
            if (i == 4 || i == 8) expect_pulse(9'd4, 3'd4, 1'b0, 1'b0, 1'b0);
            beat(8'd1);
        end
        idle();

        // Gaps, then reset aborts the partial batch
        beat(8'd7); idle(); idle(); idle(); beat(8'd7);
        do_reset();
        beat(8'd1); beat(8'd1); beat(8'd1);
        expect_pulse(9'd4, 3'd4, 1'b0, 1'b0, 1'b0);
        beat(8'd1);
        idle();

        // Taint on the first beat only
        do_reset();
        check("taint_pre_valid_t", 32'(out_valid_t), 32'd0);
        step(1'b1, 8'd1, 1'b0, 1'b1, 8'd1);
        check("taint_valid_t_set", 32'(out_valid_t), 32'd1);
        check("taint_sum_t_set", 32'(out_sum_t), 32'd1);
        beat(8'd2); beat(8'd3);
        expect_pulse(9'd10, 3'd4, 1'b0, 1'b1, 1'b1);
        beat(8'd4);
        idle(); idle(); idle();
        check("taint_valid_t_sticky", 32'(out_valid_t), 32'd1);
        check("taint_sum_t_sticky", 32'(out_sum_t), 32'd1);
        do_reset();
        check("taint_valid_t_cleared", 32'(out_valid_t), 32'd0);
        check("taint_sum_t_cleared", 32'(out_sum_t), 32'd0);

        // Two copies differing only in tainted data
        two_copy = 1'b1;
        ndiff = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) expect_pulse(9'd511, 3'd3, 1'b1, 1'b1, 1'b1);
            if (i < 4) step(1'b1, 8'd200, 1'b0, 1'b1, 8'd10);
            else idle();
            if (out_valid !== out_valid_b) begin
                ndiff++;
                check("twocopy_valid_t_a", 32'(out_valid_t), 32'd1);
                check("twocopy_valid_t_b", 32'(out_valid_t_b), 32'd1);
            end
        end
        check("twocopy_diff_cycles", 32'(ndiff), 32'd2);
        two_copy = 1'b0;

        repeat (4) idle();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
